// File: rtl/camac_cycle_engine.sv
`default_nettype none
// ============================================================================
// camac_cycle_engine: runs one CAMAC dataway cycle per host command; syncs LAM
// Revision: 1.0
// ============================================================================
module camac_cycle_engine #(
   parameter int T_SETUP = 10,
   parameter int T_S1    = 5,
   parameter int T_GAP   = 10,
   parameter int T_S2    = 5,
   parameter int T_HOLD  = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [4:0]  cmd_n,
   input  logic [3:0]  cmd_a,
   input  logic [4:0]  cmd_f,
   input  logic [23:0] cmd_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [23:0] rsp_data,
   output logic        rsp_x,
   output logic        rsp_q,
   output logic        rsp_err,
   output logic [5:0]  camac_n,
   output logic [3:0]  camac_a,
   output logic [4:0]  camac_f,
   output logic        camac_b,
   output logic        camac_s1,
   output logic        camac_s2,
   output logic        camac_z,
   output logic        camac_c,
   output logic        camac_i,
   output logic [23:0] camac_w,
   input  logic [23:0] camac_r,
   input  logic        camac_x,
   input  logic        camac_q,
   input  logic [22:0] camac_l,
   output logic [22:0] lam,
   output logic        lam_any
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      S1    = 3'd2,
      GAP   = 3'd3,
      S2    = 3'd4,
      HOLD  = 3'd5,
      RESP  = 3'd6
   } state_t;

   localparam logic [1:0] OP_NAF = 2'b00;
   localparam logic [1:0] OP_Z   = 2'b01;
   localparam logic [1:0] OP_C   = 2'b10;
   localparam logic [1:0] OP_INH = 2'b11;
   localparam int         CW     = 16;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [1:0]    op, op_nx;
   logic          cmd_ready_nx, rsp_valid_nx, rsp_x_nx, rsp_q_nx, rsp_err_nx;
   logic [23:0]   rsp_data_nx, camac_w_nx;
   logic [5:0]    camac_n_nx;
   logic [3:0]    camac_a_nx;
   logic [4:0]    camac_f_nx;
   logic          camac_b_nx, camac_s1_nx, camac_s2_nx, camac_z_nx, camac_c_nx, camac_i_nx;

   logic [23:0]   r_in;
   logic          x_in, q_in;
   logic [22:0]   lam_meta;

   always_comb begin
      state_nx     = state;
      cnt_nx       = (cnt != '0) ? cnt - CW'(1) : cnt;
      op_nx        = op;
      cmd_ready_nx = cmd_ready;
      rsp_valid_nx = rsp_valid;
      rsp_data_nx  = rsp_data;
      rsp_x_nx     = rsp_x;
      rsp_q_nx     = rsp_q;
      rsp_err_nx   = rsp_err;
      camac_n_nx   = camac_n;
      camac_a_nx   = camac_a;
      camac_f_nx   = camac_f;
      camac_w_nx   = camac_w;
      camac_b_nx   = camac_b;
      camac_s1_nx  = camac_s1;
      camac_s2_nx  = camac_s2;
      camac_z_nx   = camac_z;
      camac_c_nx   = camac_c;
      camac_i_nx   = camac_i;

      case (state)
         IDLE: begin
            cmd_ready_nx = 1'b1;
            if (cmd_valid && cmd_ready) begin
               cmd_ready_nx = 1'b0;
               op_nx        = cmd_op;
               rsp_data_nx  = '0;
               rsp_x_nx     = 1'b0;
               rsp_q_nx     = 1'b0;
               rsp_err_nx   = 1'b0;
               if (cmd_op == OP_NAF && (cmd_n == 5'd0 || cmd_n > 5'd30)) begin
                  rsp_err_nx   = 1'b1;
                  rsp_valid_nx = 1'b1;
                  state_nx     = RESP;
               end else if (cmd_op == OP_INH) begin
                  camac_i_nx   = cmd_data[0];
                  rsp_valid_nx = 1'b1;
                  state_nx     = RESP;
               end else begin
                  state_nx   = SETUP;
                  cnt_nx     = CW'(T_SETUP - 1);
                  camac_b_nx = 1'b1;
                  camac_z_nx = (cmd_op == OP_Z);
                  camac_c_nx = (cmd_op == OP_C);
                  camac_n_nx = '0;
                  camac_a_nx = '0;
                  camac_f_nx = '0;
                  camac_w_nx = '0;
                  if (cmd_op == OP_NAF) begin
                     camac_n_nx = {1'b0, cmd_n};
                     camac_a_nx = cmd_a;
                     camac_f_nx = cmd_f;
                     // Write functions are F16..F23
                     if (cmd_f[4:3] == 2'b10) camac_w_nx = cmd_data;
                  end
               end
            end
         end
         SETUP: begin
            if (cnt == '0) begin
               if (op == OP_NAF) begin
                  state_nx    = S1;
                  cnt_nx      = CW'(T_S1 - 1);
                  camac_s1_nx = 1'b1;
               end else begin
                  // Z/C fold the S1 slot into the gap so S2 lands at the same time
                  state_nx = GAP;
                  cnt_nx   = CW'(T_S1 + T_GAP - 1);
               end
            end
         end
         S1: begin
            if (cnt == '0) begin
               state_nx    = GAP;
               cnt_nx      = CW'(T_GAP - 1);
               camac_s1_nx = 1'b0;
               rsp_x_nx    = x_in;
               rsp_q_nx    = q_in;
               if (camac_f[4:3] == 2'b00) rsp_data_nx = r_in;
            end
         end
         GAP: begin
            if (cnt == '0) begin
               state_nx    = S2;
               cnt_nx      = CW'(T_S2 - 1);
               camac_s2_nx = 1'b1;
            end
         end
         S2: begin
            if (cnt == '0) begin
               state_nx    = HOLD;
               cnt_nx      = CW'(T_HOLD - 1);
               camac_s2_nx = 1'b0;
            end
         end
         HOLD: begin
            if (cnt == '0) begin
               state_nx     = RESP;
               rsp_valid_nx = 1'b1;
               camac_b_nx   = 1'b0;
               camac_n_nx   = '0;
               camac_a_nx   = '0;
               camac_f_nx   = '0;
               camac_w_nx   = '0;
               camac_z_nx   = 1'b0;
               camac_c_nx   = 1'b0;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_nx     = IDLE;
               rsp_valid_nx = 1'b0;
               cmd_ready_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         op        <= '0;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_x     <= 1'b0;
         rsp_q     <= 1'b0;
         rsp_err   <= 1'b0;
         camac_n   <= '0;
         camac_a   <= '0;
         camac_f   <= '0;
         camac_w   <= '0;
         camac_b   <= 1'b0;
         camac_s1  <= 1'b0;
         camac_s2  <= 1'b0;
         camac_z   <= 1'b0;
         camac_c   <= 1'b0;
         camac_i   <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         op        <= op_nx;
         cmd_ready <= cmd_ready_nx;
         rsp_valid <= rsp_valid_nx;
         rsp_data  <= rsp_data_nx;
         rsp_x     <= rsp_x_nx;
         rsp_q     <= rsp_q_nx;
         rsp_err   <= rsp_err_nx;
         camac_n   <= camac_n_nx;
         camac_a   <= camac_a_nx;
         camac_f   <= camac_f_nx;
         camac_w   <= camac_w_nx;
         camac_b   <= camac_b_nx;
         camac_s1  <= camac_s1_nx;
         camac_s2  <= camac_s2_nx;
         camac_z   <= camac_z_nx;
         camac_c   <= camac_c_nx;
         camac_i   <= camac_i_nx;
      end
   end

   // Dataway inputs get one register stage; LAM is asynchronous and gets two
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_in     <= '0;
         x_in     <= 1'b0;
         q_in     <= 1'b0;
         lam_meta <= '0;
         lam      <= '0;
         lam_any  <= 1'b0;
      end else begin
         r_in     <= camac_r;
         x_in     <= camac_x;
         q_in     <= camac_q;
         lam_meta <= camac_l;
         lam      <= lam_meta;
         lam_any  <= |lam;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_camac_cycle_engine.sv
`default_nettype none
// ============================================================================
// tb_camac_cycle_engine: directed + randomized checks against a timing model
// Revision: 1.0
// ============================================================================
module tb_camac_cycle_engine;

   localparam int T_SETUP = 10;
   localparam int T_S1    = 5;
   localparam int T_GAP   = 10;
   localparam int T_S2    = 5;
   localparam int T_HOLD  = 10;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_op;
   logic [4:0]  cmd_n;
   logic [3:0]  cmd_a;
   logic [4:0]  cmd_f;
   logic [23:0] cmd_data;
   logic        rsp_valid, rsp_ready;
   logic [23:0] rsp_data;
   logic        rsp_x, rsp_q, rsp_err;
   logic [5:0]  camac_n;
   logic [3:0]  camac_a;
   logic [4:0]  camac_f;
   logic        camac_b, camac_s1, camac_s2, camac_z, camac_c, camac_i;
   logic [23:0] camac_w, camac_r;
   logic        camac_x, camac_q;
   logic [22:0] camac_l, lam;
   logic        lam_any;

   int   checks = 0;
   int   errors = 0;
   logic exp_i  = 1'b0;

   wire logic [97:0] all_out = {cmd_ready, rsp_valid, rsp_data, rsp_x, rsp_q, rsp_err,
                                camac_n, camac_a, camac_f, camac_b, camac_s1, camac_s2,
                                camac_z, camac_c, camac_i, camac_w, lam, lam_any};

   camac_cycle_engine #(
      .T_SETUP(T_SETUP), .T_S1(T_S1), .T_GAP(T_GAP), .T_S2(T_S2), .T_HOLD(T_HOLD)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_n(cmd_n),
      .cmd_a(cmd_a), .cmd_f(cmd_f), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_x(rsp_x), .rsp_q(rsp_q), .rsp_err(rsp_err),
      .camac_n(camac_n), .camac_a(camac_a), .camac_f(camac_f), .camac_b(camac_b),
      .camac_s1(camac_s1), .camac_s2(camac_s2), .camac_z(camac_z), .camac_c(camac_c),
      .camac_i(camac_i), .camac_w(camac_w), .camac_r(camac_r), .camac_x(camac_x),
      .camac_q(camac_q), .camac_l(camac_l), .lam(lam), .lam_any(lam_any)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issues one command and checks bus trace and response against the model.
   task automatic do_cmd(input logic [1:0] op, input logic [4:0] n, input logic [3:0] a,
                         input logic [4:0] f, input logic [23:0] d, input logic [23:0] r,
                         input logic x, input logic q, input int hold);
      bit          is_err, naf, bus;
      int          e_b, e_s1f, e_s1l, e_s2f, e_s2l;
      logic [23:0] e_data, e_w;
      logic        e_x, e_q;
      int          idx, bcnt, s1f, s1l, s2f, s2l, bad, wcyc, unstable;

      is_err = (op == 2'd0) && (n == 5'd0 || n > 5'd30);
      naf    = (op == 2'd0) && !is_err;
      bus    = naf || op == 2'd1 || op == 2'd2;
      e_b    = bus ? T_SETUP + T_S1 + T_GAP + T_S2 + T_HOLD : 0;
      e_s1f  = naf ? T_SETUP + 1 : 0;
      e_s1l  = naf ? T_SETUP + T_S1 : 0;
      e_s2f  = bus ? T_SETUP + T_S1 + T_GAP + 1 : 0;
      e_s2l  = bus ? T_SETUP + T_S1 + T_GAP + T_S2 : 0;
      e_data = (naf && f < 8) ? r : 24'd0;
      e_x    = naf ? x : 1'b0;
      e_q    = naf ? q : 1'b0;
      e_w    = (naf && f >= 16 && f <= 23) ? d : 24'd0;

      @(negedge clk);
      camac_r   = r;
      camac_x   = x;
      camac_q   = q;
      rsp_ready = (hold == 0);
      cmd_op    = op;
      cmd_n     = n;
      cmd_a     = a;
      cmd_f     = f;
      cmd_data  = d;
      cmd_valid = 1'b1;
      wcyc = 0;
      while (!cmd_ready && wcyc < 200) begin
         @(negedge clk);
         wcyc++;
      end
      check("accept_timeout", (wcyc >= 200), 0);
      @(negedge clk);
      cmd_valid = 1'b0;

      idx = 0; bcnt = 0; s1f = 0; s1l = 0; s2f = 0; s2l = 0; bad = 0;
      while (!rsp_valid && idx < 200) begin
         idx++;
         if (camac_b) bcnt++;
         if (camac_s1) begin
            if (s1f == 0) s1f = idx;
            s1l = idx;
         end
         if (camac_s2) begin
            if (s2f == 0) s2f = idx;
            s2l = idx;
         end
         if (camac_n !== (naf ? {1'b0, n} : 6'd0) || camac_a !== (naf ? a : 4'd0) ||
             camac_f !== (naf ? f : 5'd0) || camac_w !== e_w ||
             camac_z !== (op == 2'd1) || camac_c !== (op == 2'd2) ||
             camac_i !== exp_i || !camac_b || cmd_ready)
            bad++;
         @(negedge clk);
      end
      if (op == 2'd3) exp_i = d[0];

      check("rsp_valid", rsp_valid, 1);
      check("busy_cycles", bcnt, e_b);
      check("s1_first", s1f, e_s1f);
      check("s1_last", s1l, e_s1l);
      check("s2_first", s2f, e_s2f);
      check("s2_last", s2l, e_s2l);
      check("bus_lines", bad, 0);
      check("rsp_data", rsp_data, e_data);
      check("rsp_xq_err", {rsp_x, rsp_q, rsp_err}, {e_x, e_q, is_err});
      check("bus_released", {camac_b, camac_s1, camac_s2, camac_z, camac_c,
                             camac_n, camac_a, camac_f, camac_w}, 0);
      check("inhibit", camac_i, exp_i);

      if (hold > 0) begin
         unstable = 0;
         repeat (hold) begin
            @(negedge clk);
            if (!rsp_valid || cmd_ready || rsp_data !== e_data ||
                {rsp_x, rsp_q, rsp_err} !== {e_x, e_q, is_err})
               unstable++;
         end
         check("rsp_hold_stable", unstable, 0);
         rsp_ready = 1'b1;
      end
      @(negedge clk);
      check("handshake", {rsp_valid, cmd_ready}, 2'b01);
   endtask

   initial begin
      int          wcyc, vcnt;
      logic [22:0] lv;

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_n = '0; cmd_a = '0; cmd_f = '0;
      cmd_data = '0; rsp_ready = 1'b1; camac_r = '0; camac_x = 1'b0; camac_q = 1'b0;
      camac_l = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", all_out, 0);
      rst_n = 1'b1;
      check("ready_before_edge", cmd_ready, 0);
      @(negedge clk);
      check("ready_after_release", cmd_ready, 1);

      do_cmd(2'd0, 5'd5, 4'd2, 5'd0, 24'h0F0F0F, 24'hA5C3E1, 1'b1, 1'b1, 0);
      do_cmd(2'd0, 5'd3, 4'd0, 5'd16, 24'h123456, 24'h777777, 1'b1, 1'b0, 0);
      do_cmd(2'd1, 5'd7, 4'd3, 5'd17, 24'hABCDEF, 24'h111111, 1'b1, 1'b1, 0);
      do_cmd(2'd2, 5'd9, 4'd5, 5'd9, 24'h654321, 24'h222222, 1'b1, 1'b1, 0);
      do_cmd(2'd0, 5'd0, 4'd1, 5'd0, 24'h000000, 24'h333333, 1'b1, 1'b1, 0);
      do_cmd(2'd0, 5'd31, 4'd1, 5'd16, 24'h444444, 24'h555555, 1'b1, 1'b1, 0);
      do_cmd(2'd0, 5'd30, 4'd15, 5'd7, 24'h000000, 24'hFEDCBA, 1'b0, 1'b1, 20);
      do_cmd(2'd0, 5'd12, 4'd4, 5'd24, 24'h999999, 24'h888888, 1'b1, 1'b1, 0);
      do_cmd(2'd3, 5'd0, 4'd0, 5'd0, 24'h000001, 24'h000000, 1'b0, 1'b0, 0);
      do_cmd(2'd0, 5'd1, 4'd6, 5'd23, 24'hC0FFEE, 24'h0BADF0, 1'b0, 1'b1, 0);

      @(negedge clk);
      camac_l = 23'h000400;
      repeat (2) @(negedge clk);
      check("lam_2clk", {lam, lam_any}, {23'h000400, 1'b0});
      @(negedge clk);
      check("lam_any_3clk", lam_any, 1);

      repeat (16) begin
         do_cmd(2'($urandom_range(0, 3)), 5'($urandom), 4'($urandom), 5'($urandom),
                24'($urandom), 24'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 3));
      end

      repeat (4) begin
         lv = 23'($urandom);
         if ($urandom_range(0, 1) == 0) lv = '0;
         camac_l = lv;
         repeat (3) @(negedge clk);
         check("lam_random", {lam, lam_any}, {lv, (lv != 23'd0)});
      end

      // Reset in the middle of S1 with inhibit set and LAM active
      do_cmd(2'd3, 5'd0, 4'd0, 5'd0, 24'h000001, 24'h000000, 1'b0, 1'b0, 0);
      camac_l = 23'h7FFFFF;
      @(negedge clk);
      cmd_op = 2'd0; cmd_n = 5'd4; cmd_a = 4'd1; cmd_f = 5'd0; cmd_valid = 1'b1;
      rsp_ready = 1'b1;
      wcyc = 0;
      while (!cmd_ready && wcyc < 100) begin @(negedge clk); wcyc++; end
      @(negedge clk);
      cmd_valid = 1'b0;
      while (!camac_s1 && wcyc < 100) begin @(negedge clk); wcyc++; end
      check("reach_s1", camac_s1, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("midcycle_reset", all_out, 0);
      exp_i = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("ready_held_low", cmd_ready, 0);
      @(negedge clk);
      check("ready_after_midreset", cmd_ready, 1);
      vcnt = 0;
      repeat (5) begin
         @(negedge clk);
         if (rsp_valid) vcnt++;
      end
      check("no_rsp_after_reset", vcnt, 0);
      camac_l = '0;

      do_cmd(2'd0, 5'd22, 4'd9, 5'd2, 24'h000000, 24'h5A5A5A, 1'b1, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/camac_cycle_engine.md
Name: camac_cycle_engine

Overview:
- Executes one CAMAC dataway cycle per decoded host command: NAF, Z (initialise), C (clear) and inhibit control.
- Sits directly downstream of the serial command decoder inside Messbauer_CAMAC_Controller and drives the camac_* pins, which are active-high at this boundary; pad inversion is done elsewhere.
- Returns read data, X and Q to the response path.
- Also synchronises the 23 LAM lines for the host status path.

Parameters:
- T_SETUP, 10, clocks from N/A/F/W/B valid to S1 rising (200 ns at 50 MHz)
- T_S1, 5, S1 width in clocks
- T_GAP, 10, clocks from S1 falling to S2 rising
- T_S2, 5, S2 width in clocks
- T_HOLD, 10, clocks from S2 falling to bus release

Ports:
- clk in 1: system clock, 50 MHz
- rst_n in 1: synchronous reset, active-low
- cmd_valid in 1: command offered
- cmd_ready out 1: engine idle; command accepted when cmd_valid & cmd_ready
- cmd_op in 2: 00 NAF, 01 Z, 10 C, 11 set inhibit
- cmd_n in 5: station number
- cmd_a in 4: subaddress
- cmd_f in 5: function code
- cmd_data in 24: write data (op 11: bit0 = inhibit value)
- rsp_valid out 1: response available
- rsp_ready in 1: response consumed when rsp_valid & rsp_ready
- rsp_data out 24: read data
- rsp_x out 1: X response
- rsp_q out 1: Q response
- rsp_err out 1: command rejected
- camac_n out 6: station, binary; bit5 always 0
- camac_a out 4: subaddress
- camac_f out 5: function
- camac_b out 1: busy
- camac_s1 out 1: strobe 1
- camac_s2 out 1: strobe 2
- camac_z out 1: initialise
- camac_c out 1: clear
- camac_i out 1: inhibit level
- camac_w out 24: write lines
- camac_r in 24: read lines
- camac_x in 1: X response line
- camac_q in 1: Q response line
- camac_l in 23: LAM lines
- lam out 23: synchronised LAM
- lam_any out 1: OR of lam

Behaviour:
- Reset values: every output is 0. cmd_ready is registered and becomes 1 on the first clock with rst_n high.
- Reset mid-cycle: the next edge forces IDLE and drops all bus lines. No response is produced. camac_i is cleared.
- camac_r, camac_x and camac_q pass through one input register stage. camac_l passes through a 2-FF synchroniser; lam_any is registered from the synchronised value, so total latency is 3 clocks.
- States: IDLE, SETUP, S1, GAP, S2, HOLD, RESP. A single down-counter loads each state's duration on entry.
- IDLE: on accept, latch the command, cmd_ready <= 0.
  - NAF with cmd_n == 0 or cmd_n > 30: go to RESP with rsp_err = 1, no bus activity.
  - Op 11: camac_i <= cmd_data[0], go to RESP.
  - Otherwise: go to SETUP.
- SETUP: camac_b = 1.
  - NAF: N/A/F are driven.
  - Z/C: N/A/F stay 0.
  - camac_w = data only when F is 16..23, else 0.
- S1 (NAF only): camac_s1 = 1. On the last S1 clock, latch the registered X and Q. Also latch R, but only when F is 0..7; otherwise rsp_data = 0.
- Z/C skip S1: SETUP is followed by GAP of T_S1 + T_GAP clocks, so S2 timing is identical for all ops.
- S2: camac_s2 = 1. camac_z = 1 (op Z) or camac_c = 1 (op C) for the whole span SETUP..HOLD.
- HOLD: lines stay driven. On exit, all bus lines except camac_i are cleared in the same edge as entering RESP.
- NAF total bus time is T_SETUP + T_S1 + T_GAP + T_S2 + T_HOLD = 40 clocks, with camac_b high for exactly 40 clocks.
- RESP: rsp_valid = 1; the response fields are held stable until rsp_ready.
  - On handshake: rsp_valid <= 0, cmd_ready <= 1, go to IDLE.
  - If rsp_ready is already high on RESP entry, the handshake completes that cycle.
  - Z/C responses: x = q = 0, data = 0, err = 0.
- No command is accepted while rsp_valid is high. A cmd_valid held across that time is taken on the first cmd_ready cycle.
- camac_i persists across cycles until the next op 11 or reset.

Test Plan:
- Reset: hold rst_n = 0 for 3 clocks during a NAF in S1 -> all outputs 0 next edge. cmd_ready = 1 one clock after release; no rsp_valid.
- Read: N=5, A=2, F=0, with camac_r = 24'hA5C3E1, X = 1, Q = 1, rsp_ready = 1 -> camac_b high 40 clocks, s1 high clocks 11..15, s2 high clocks 26..30. Response data = A5C3E1, x = q = 1, err = 0; camac_w stays 0.
- Write: N=3, A=0, F=16, data = 24'h123456, Q = 0 -> camac_w = 123456 for all 40 busy clocks. rsp_data = 0, q = 0.
- Z then C: expect camac_z (then camac_c) high for 40 clocks, s1 never high, s2 pulse of 5 clocks. N/A/F = 0; response x = q = 0.
- Errors and backpressure: N = 0 -> rsp_err = 1 with no camac_b activity. NAF with rsp_ready = 0 for 20 clocks -> response stable and cmd_ready low until the handshake.
- Inhibit and LAM: op 11 data = 1 -> camac_i = 1 persisting through a following NAF. Drive camac_l = 23'h000400 -> lam = 000400 and lam_any = 1 after 3 clocks.
